// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
// Single outstanding request; rdata carries an 8-byte-aligned instruction pair.
interface fetch_ctrl_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                     imem_req_o;
  logic [PC_WIDTH-1:0]      imem_addr_o;
  logic                     imem_gnt_i;
  logic                     imem_rvalid_i;
  logic [2*INSTR_WIDTH-1:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues pair fetches to imem, buffers one returned pair and
// hands it to the decoder; honours ROB stalls and flush/branch/jump redirects.
module fetch_ctrl #(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_ctrl_if.master           imem,
  input  logic                   rob_full_i,
  input  logic                   flush_en_i,
  input  logic [PC_WIDTH-1:0]    flush_PC_i,
  input  logic                   branch_en_i,
  input  logic [PC_WIDTH-1:0]    branch_PC_i,
  input  logic                   jump_en_i,
  input  logic [PC_WIDTH-1:0]    jump_PC_i,
  output logic [INSTR_WIDTH-1:0] instruction1_o,
  output logic [INSTR_WIDTH-1:0] instruction2_o,
  output logic                   ins1_valid_o,
  output logic                   ins2_valid_o,
  output logic [PC_WIDTH-1:0]    PC_in1_o,
  output logic [PC_WIDTH-1:0]    PC_in2_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_e;

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(7);

  state_e                   state_q, state_d;
  logic [PC_WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
  logic                     skip1_q, skip1_d;
  logic                     pv_q, pv_d;
  logic [2*INSTR_WIDTH-1:0] buf_q, buf_d;
  logic [PC_WIDTH-1:0]      pair_pc_q, pair_pc_d;
  logic                     pair_skip1_q, pair_skip1_d;
  logic [PC_WIDTH-1:0]      req_pc_q, req_pc_d;
  logic                     req_skip1_q, req_skip1_d;

  logic                     redirect;
  logic [PC_WIDTH-1:0]      target;
  logic                     dispatch;
  logic                     req;

  assign redirect = flush_en_i | branch_en_i | jump_en_i;
  assign target   = flush_en_i  ? flush_PC_i  :
                    branch_en_i ? branch_PC_i : jump_PC_i;
  assign dispatch = pv_q & ~rob_full_i & ~redirect;
  // Gated by rst so the bus is quiet while reset is held.
  assign req      = rst & (state_q == S_REQ) & (~pv_q | dispatch) & ~redirect;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = fetch_pc_q;

  assign ins1_valid_o   = dispatch & ~pair_skip1_q;
  assign ins2_valid_o   = dispatch;
  assign instruction1_o = pv_q ? buf_q[INSTR_WIDTH-1:0]             : '0;
  assign instruction2_o = pv_q ? buf_q[2*INSTR_WIDTH-1:INSTR_WIDTH] : '0;
  assign PC_in1_o       = pv_q ? pair_pc_q                          : '0;
  assign PC_in2_o       = pv_q ? pair_pc_q + PC_WIDTH'(4)           : '0;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    skip1_d      = skip1_q;
    pv_d         = pv_q;
    buf_d        = buf_q;
    pair_pc_d    = pair_pc_q;
    pair_skip1_d = pair_skip1_q;
    req_pc_d     = req_pc_q;
    req_skip1_d  = req_skip1_q;

    if (dispatch) pv_d = 1'b0;

    case (state_q)
      S_REQ: begin
        if (req && imem.imem_gnt_i) begin
          state_d     = S_WAIT;
          req_pc_d    = fetch_pc_q;
          req_skip1_d = skip1_q;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid_i) begin
          state_d = S_REQ;
          if (!redirect) begin
            buf_d        = imem.imem_rdata_i;
            pair_pc_d    = req_pc_q;
            pair_skip1_d = req_skip1_q;
            pv_d         = 1'b1;
            fetch_pc_d   = fetch_pc_q + PC_WIDTH'(8);
            skip1_d      = 1'b0;
          end
        end else if (redirect) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem.imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides everything above except the state transition.
    if (redirect) begin
      pv_d       = 1'b0;
      fetch_pc_d = target & ALIGN_MASK;
      skip1_d    = target[2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC & ALIGN_MASK;
      skip1_q      <= RESET_PC[2];
      pv_q         <= 1'b0;
      buf_q        <= '0;
      pair_pc_q    <= '0;
      pair_skip1_q <= 1'b0;
      req_pc_q     <= '0;
      req_skip1_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      skip1_q      <= skip1_d;
      pv_q         <= pv_d;
      buf_q        <= buf_d;
      pair_pc_q    <= pair_pc_d;
      pair_skip1_q <= pair_skip1_d;
      req_pc_q     <= req_pc_d;
      req_skip1_q  <= req_skip1_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes expected grants and
// dispatched pairs; a negedge monitor pops and compares as the DUT presents them.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        rob_full;
  logic        flush_en, branch_en, jump_en;
  logic [31:0] flush_pc, branch_pc, jump_pc;
  logic [31:0] instr1, instr2, pc1, pc2;
  logic        v1, v2;

  fetch_ctrl_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) imem ();

  fetch_ctrl #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .rob_full_i     (rob_full),
    .flush_en_i     (flush_en),
    .flush_PC_i     (flush_pc),
    .branch_en_i    (branch_en),
    .branch_PC_i    (branch_pc),
    .jump_en_i      (jump_en),
    .jump_PC_i      (jump_pc),
    .instruction1_o (instr1),
    .instruction2_o (instr2),
    .ins1_valid_o   (v1),
    .ins2_valid_o   (v2),
    .PC_in1_o       (pc1),
    .PC_in2_o       (pc2)
  );

  typedef struct {
    logic [31:0] pc;
    logic        v1;
  } pair_t;

  logic [31:0] addr_q[$];
  pair_t       pair_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned mem_delay = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory model: grant always, rvalid mem_delay cycles after the cycle following gnt.
  initial begin : mem_model
    logic        pend;
    logic [31:0] paddr;
    int unsigned cnt;
    pend = 1'b0;
    paddr = '0;
    cnt = 0;
    imem.imem_gnt_i    = 1'b1;
    imem.imem_rvalid_i = 1'b0;
    imem.imem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      if (imem.imem_rvalid_i) pend = 1'b0;
      if (imem.imem_req_o && imem.imem_gnt_i) begin
        pend  = 1'b1;
        paddr = imem.imem_addr_o;
        cnt   = mem_delay;
      end
      #2;
      if (!rst) begin
        pend = 1'b0;
        imem.imem_rvalid_i = 1'b0;
      end else if (pend && cnt == 0) begin
        imem.imem_rvalid_i = 1'b1;
        imem.imem_rdata_i  = {word(paddr + 32'd4), word(paddr)};
      end else begin
        imem.imem_rvalid_i = 1'b0;
        if (pend) cnt--;
      end
    end
  end

  initial begin : monitor
    logic [31:0] ea;
    pair_t       ep;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (imem.imem_req_o && imem.imem_gnt_i) begin
          if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr %h expected none at %0t", imem.imem_addr_o, $time);
          end else begin
            ea = addr_q.pop_front();
            chk("req_addr", imem.imem_addr_o, ea);
          end
        end
        if (v2) begin
          if (pair_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pair: got pc %h expected none at %0t", pc1, $time);
          end else begin
            ep = pair_q.pop_front();
            chk("ins1_valid", {31'd0, v1}, {31'd0, ep.v1});
            chk("PC_in1", pc1, ep.pc);
            chk("PC_in2", pc2, ep.pc + 32'd4);
            chk("instruction1", instr1, word(ep.pc));
            chk("instruction2", instr2, word(ep.pc + 32'd4));
          end
        end else if (v1) begin
          checks++;
          errors++;
          $display("FAIL ins1_without_ins2: got 1 expected 0 at %0t", $time);
        end
      end
    end
  end

  task automatic wait_grant(input logic [31:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (imem.imem_req_o && imem.imem_gnt_i && imem.imem_addr_o == a) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant expected addr %h", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, imem.imem_req_o}, 32'd0);
    chk({tag, "_v1"}, {31'd0, v1}, 32'd0);
    chk({tag, "_v2"}, {31'd0, v2}, 32'd0);
    chk({tag, "_pc1"}, pc1, 32'd0);
    chk({tag, "_pc2"}, pc2, 32'd0);
    chk({tag, "_instr1"}, instr1, 32'd0);
    chk({tag, "_addr"}, imem.imem_addr_o, 32'd0);
  endtask

  initial begin : stim
    rst = 1'b0;
    rob_full = 1'b0;
    flush_en = 1'b0;  flush_pc  = '0;
    branch_en = 1'b0; branch_pc = '0;
    jump_en = 1'b0;   jump_pc   = '0;

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");

    // Straight-line streaming from RESET_PC.
    addr_q.push_back(32'h0);  addr_q.push_back(32'h8);  addr_q.push_back(32'h10);
    pair_q.push_back('{32'h0, 1'b1});
    pair_q.push_back('{32'h8, 1'b1});
    @(posedge clk); #1;
    rst = 1'b1;
    wait_grant(32'h10);

    // ROB stall holds pair 0x10.
    rob_full = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_v1", {31'd0, v1}, 32'd0);
      chk("stall_v2", {31'd0, v2}, 32'd0);
      chk("stall_req", {31'd0, imem.imem_req_o}, 32'd0);
      chk("stall_pc1", pc1, 32'h10);
      chk("stall_instr1", instr1, word(32'h10));
      chk("stall_instr2", instr2, word(32'h14));
    end
    pair_q.push_back('{32'h10, 1'b1});
    addr_q.push_back(32'h18);
    addr_q.push_back(32'h100);
    pair_q.push_back('{32'h100, 1'b0});
    @(posedge clk); #1;
    rob_full  = 1'b0;
    mem_delay = 2;
    wait_grant(32'h18);

    // Branch while waiting: stale response must drain.
    branch_en = 1'b1; branch_pc = 32'h104;
    @(posedge clk); #1;
    branch_en = 1'b0;
    addr_q.push_back(32'h108);
    addr_q.push_back(32'h200);
    pair_q.push_back('{32'h200, 1'b1});
    wait_grant(32'h100);
    mem_delay = 0;

    // Flush and jump together, coinciding with rvalid.
    wait_grant(32'h108);
    flush_en = 1'b1; flush_pc = 32'h200;
    jump_en  = 1'b1; jump_pc  = 32'h300;
    @(posedge clk); #1;
    flush_en = 1'b0; jump_en = 1'b0;

    // Jump near the top of the address space, then wrap.
    addr_q.push_back(32'h208);
    addr_q.push_back(32'hFFFF_FFF8);
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h8);
    pair_q.push_back('{32'hFFFF_FFF8, 1'b0});
    pair_q.push_back('{32'h0, 1'b1});
    wait_grant(32'h208);
    jump_en = 1'b1; jump_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    jump_en = 1'b0;
    wait_grant(32'h8);

    // Reset while waiting on a response.
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midreset");
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h8);
    pair_q.push_back('{32'h0, 1'b1});
    @(posedge clk); #1;
    rst = 1'b1;
    wait_grant(32'h0);
    wait_grant(32'h8);
    rob_full = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("addr_queue_empty", addr_q.size(), 32'd0);
    chk("pair_queue_empty", pair_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Front-end fetch sequencer for the dual-issue superscalar core. It generates the fetch PC and runs a single-outstanding req/gnt/rvalid handshake to instruction memory, fetching one 8-byte-aligned instruction pair per request. It holds each returned pair in a one-entry buffer and presents it to the decoder as instruction1/instruction2 with valids and PCs. It stalls on ROB full and applies flush/branch/jump redirects from the ROB, discarding stale responses.

Parameters:
PC_WIDTH, 32, width of PCs and instruction-memory address
INSTR_WIDTH, 32, width of one instruction; imem data is 2*INSTR_WIDTH
RESET_PC, 0, first fetch PC after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
imem_req_o  out  1  fetch request
imem_addr_o  out  PC_WIDTH  request address, bits [2:0] always 0
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response data valid
imem_rdata_i  in  2*INSTR_WIDTH  [INSTR_WIDTH-1:0] = word at addr, upper half = word at addr+4
rob_full_i  in  1  ROB cannot accept; stall dispatch
flush_en_i / flush_PC_i  in  1 / PC_WIDTH  flush redirect
branch_en_i / branch_PC_i  in  1 / PC_WIDTH  taken-branch redirect
jump_en_i / jump_PC_i  in  1 / PC_WIDTH  jump redirect
instruction1_o / instruction2_o  out  INSTR_WIDTH  pair to decoder
ins1_valid_o / ins2_valid_o  out  1  slot valid
PC_in1_o / PC_in2_o  out  PC_WIDTH  slot PCs; PC_in2_o = PC_in1_o + 4

Behaviour:
- States: REQ (may issue), WAIT (granted, awaiting rvalid), DRAIN (awaiting stale rvalid to discard).
- Reset (rst=0, async): state=REQ; fetch_pc=RESET_PC with [2:0] cleared; skip1=RESET_PC[2]; buffer valid pv=0; all outputs 0.
- redirect = flush_en_i | branch_en_i | jump_en_i. Priority flush > branch > jump; the lower-priority target is ignored.
- dispatch = pv & !rob_full_i & !redirect.
- ins1_valid_o = dispatch & !pair_skip1. ins2_valid_o = dispatch. Data and PC outputs show buffer contents whenever pv=1.
- imem_req_o = (state==REQ) & (!pv | dispatch) & !redirect. imem_addr_o = fetch_pc.
- REQ: on req&gnt, go to WAIT and latch the request's skip1 and address.
- WAIT: on rvalid, load buffer (data, pair_pc, pair_skip1), set pv=1, fetch_pc += 8 (wraps modulo 2^PC_WIDTH), skip1=0, go to REQ. Earliest rvalid is the cycle after gnt.
- Buffer is always free when rvalid arrives, because a request is only issued if the buffer is empty or draining that cycle.
- Dispatch with no same-cycle load clears pv.
- Redirect in any state:
  - pv<=0; fetch_pc<=target with [2:0] cleared; skip1<=target[2].
  - REQ stays REQ; no request issues in the redirect cycle.
  - WAIT goes to DRAIN, unless rvalid arrives the same cycle, in which case the data is discarded and state goes to REQ.
  - DRAIN stays DRAIN and updates the target.
- DRAIN: rvalid is discarded, then go to REQ.
- rvalid in REQ state is ignored.
- rob_full held: pair stays in the buffer, outputs stay stable, no further request is issued.
- Reset mid-WAIT: returns to REQ. Memory must not return a response for a request that was granted before reset.

Test Plan:
- Reset, RESET_PC=0, gnt=1, rvalid 1 cycle after gnt, rob_full=0 -> addrs 0x0, 0x8, 0x10; both valids set; PC_in1=0x0/PC_in2=0x4, then 0x8/0xC.
- rob_full=1 for 3 cycles while pv=1 -> both valids 0, outputs stable, imem_req_o=0. rob_full drops -> pair dispatched once, next request issued the same cycle.
- branch_en=1, branch_PC=0x104 while in WAIT -> stale rvalid discarded (no valid output), next addr 0x100, first pair has ins1_valid=0, ins2_valid=1, PC_in2=0x104.
- flush_en and jump_en asserted together (flush_PC=0x200, jump_PC=0x300) -> next addr 0x200.
- Redirect in the same cycle as rvalid in WAIT -> data discarded, state REQ, next addr equals the target.
- fetch_pc=0xFFFFFFF8 with response received -> next addr 0x0 (wrap); rst asserted mid-WAIT -> outputs 0 immediately, fetch restarts at RESET_PC.
